// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, opcode
// constants and the PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE  = 6'b000000;
    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with sequential increment and word-aligned
// redirect; a redirect wins over a sequential advance.
module fetch_pc
    import mips_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_next,
    input  logic                load_target,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~{{(PC_WIDTH-2){1'b0}}, 2'b11};

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target_aligned;

    assign pc_inc         = pc + PC_WIDTH'(PC_INC);
    assign target_aligned = target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load_target) begin
            pc <= target_aligned;
        end else if (load_next) begin
            pc <= pc_inc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem reads, stall and branch
// redirect, with stale responses discarded after a redirect.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [5:0]          if_opcode,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_pc_plus4
);

    fetch_state_t        state, next_state;
    logic                discard, next_discard;
    logic                load_next, load_target;
    logic                capture, clear_valid;
    logic [PC_WIDTH-1:0] pc;

    fetch_pc #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_next   (load_next),
        .load_target (load_target),
        .target      (branch_target),
        .pc          (pc)
    );

    assign imem_addr   = pc;
    assign if_opcode   = if_instr[31:26];
    assign if_pc_plus4 = if_pc + PC_WIDTH'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            discard <= 1'b0;
        end else begin
            state   <= next_state;
            discard <= next_discard;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_instr <= INSTR_NOP;
            if_pc    <= RESET_PC;
        end else if (capture) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
        end else if (clear_valid) begin
            if_valid <= 1'b0;
        end
    end

    // A redirect that coincides with an issued request leaves one stale
    // response in flight, which the discard flag swallows.
    always_comb begin
        next_state   = state;
        next_discard = discard;
        load_next    = 1'b0;
        load_target  = 1'b0;
        capture      = 1'b0;
        clear_valid  = 1'b0;
        imem_req     = 1'b0;
        unique case (state)
            IDLE: begin
                next_state = REQ;
            end
            REQ: begin
                imem_req   = 1'b1;
                next_state = WAIT;
                if (branch_taken) begin
                    load_target  = 1'b1;
                    next_discard = 1'b1;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    load_target = 1'b1;
                    if (imem_ready) begin
                        next_discard = 1'b0;
                        next_state   = REQ;
                    end else begin
                        next_discard = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (discard) begin
                        next_discard = 1'b0;
                        next_state   = REQ;
                    end else begin
                        capture    = 1'b1;
                        load_next  = 1'b1;
                        next_state = VALID;
                    end
                end
            end
            VALID: begin
                if (branch_taken) begin
                    load_target = 1'b1;
                    clear_valid = 1'b1;
                    if (stall) begin
                        next_state = REQ;
                    end else begin
                        imem_req     = 1'b1;
                        next_discard = 1'b1;
                        next_state   = WAIT;
                    end
                end else if (!stall) begin
                    imem_req    = 1'b1;
                    clear_valid = 1'b1;
                    next_state  = WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the main control decoder. It owns the PC and issues single-outstanding word reads to instruction memory over a req/ready handshake. It holds the returned instruction in an output register and presents its opcode field [31:26] to the decoder. It supports downstream stall and branch redirect, discarding stale responses after a redirect.

Parameters:
PC_WIDTH, 32, width of PC, imem_addr, if_pc, if_pc_plus4.
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request, one-cycle pulse; address valid the same cycle
imem_addr  out  PC_WIDTH  byte address of the request (equals the current pc)
imem_ready  in  1  response strobe; imem_rdata valid this cycle; at least 1 cycle after imem_req
imem_rdata  in  32  instruction word
stall  in  1  downstream cannot accept; hold the current instruction
branch_taken  in  1  redirect pulse from the branch resolution logic
branch_target  in  PC_WIDTH  redirect address; bits [1:0] ignored and forced to 0
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_instr  out  32  fetched instruction register
if_opcode  out  6  if_instr[31:26], combinational; feeds the decoder opcode input
if_pc  out  PC_WIDTH  address of if_instr
if_pc_plus4  out  PC_WIDTH  if_pc+4, wraps modulo 2^PC_WIDTH

Behaviour:
- Reset values (async on rst_n low): state=IDLE, pc=RESET_PC, discard=0, if_valid=0, if_instr=0, if_pc=RESET_PC, imem_req=0. imem_ready is ignored in IDLE. imem must share rst_n so no pre-reset response arrives later.
- States: IDLE, REQ, WAIT, VALID. imem_req=1 in REQ, and in VALID when stall=0; 0 otherwise. imem_addr=pc always.
- IDLE -> REQ unconditionally next cycle; first request goes out 2 cycles after rst_n rises.
- REQ -> WAIT.
- WAIT, imem_ready=0: stay.
- WAIT, imem_ready=1, discard=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, -> VALID.
- WAIT, imem_ready=1, discard=1: drop the data, discard<=0, -> REQ. if_valid stays 0.
- VALID, stall=1: hold all outputs. No request is issued.
- VALID, stall=0: the instruction is consumed this cycle. A new request is issued, if_valid<=0, -> WAIT.
- Throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect (branch_taken=1; priority over stall, ignored in IDLE): pc<=branch_target&~3, if_valid<=0.
  - REQ, or VALID with stall=0 (request issued this cycle): discard<=1, -> WAIT.
  - VALID with stall=1 (no request this cycle): -> REQ.
  - WAIT with imem_ready=0: discard<=1, stay in WAIT.
  - WAIT with imem_ready=1: drop the response, discard<=0, -> REQ.
  - Repeated redirect while discard=1: pc updates again, discard stays 1. Only one response is ever outstanding.
- Wrap: pc+4 from 2^PC_WIDTH-4 gives 0; no error flag.
- if_valid never rises in the same cycle as branch_taken.
- Reset mid-WAIT: the outstanding request is abandoned, and fetch restarts at RESET_PC through IDLE.

Decomposition:
- Shared package mips_pkg: state encodings (IDLE/REQ/WAIT/VALID); opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100; INSTR_NOP=32'h0; PC_INC=4.
- One sub-module: fetch_pc. It holds the pc register, the +4 incrementer and the aligned redirect mux, with load_next and load_target enables.
- The FSM, discard flag and output register stay in fetch_stage.

Test Plan:
1. Reset release, 1-cycle memory returning 32'h8C010004 at 0x0 and 32'h00221820 at 0x4, stall=0 -> imem_req pulses at addr 0x0 then 0x4; if_opcode=6'b100011 then 6'b000000; if_pc=0x0 then 0x4; one valid every 2 cycles.
2. Stall held 3 cycles while if_valid=1 with if_instr=32'hAC020008 -> if_instr/if_pc stable, no imem_req; request for the next pc issued the cycle stall drops.
3. branch_taken with target 0x0000_0043 while in WAIT, memory latency 3 -> old response dropped, if_valid stays 0, next imem_addr=0x40, instruction from 0x40 delivered with if_pc=0x40.
4. branch_taken in the same cycle as imem_ready -> response dropped, the following cycle issues a request to the target; two redirects back-to-back -> only the last target is fetched.
5. RESET_PC=32'hFFFF_FFFC -> second request goes to 0x0000_0000 and if_pc_plus4=0x0 for the first instruction.
6. rst_n asserted mid-WAIT -> all outputs return to reset values asynchronously (before the next clk edge); after release, fetch restarts at RESET_PC.
